// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, handshake
// states and the width of the line index.
package irq_pkg;

  localparam int IRQ_ID_W = 3;
  localparam int HWINT_W  = 6;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_CUR  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index
// of the lowest-numbered one.
module prio_enc
  import irq_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0]        req_i,
  output logic                any_o,
  output logic [IRQ_ID_W-1:0] id_o
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    any_o = |req_i;
    id_o  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = IRQ_ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches device pulses, masks and prioritises them, and
// runs the request / acknowledge / end-of-interrupt handshake with CP0.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N = 6
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N-1:0]        DevIRQ,
  input  logic [1:0]          Addr,
  input  logic                We,
  input  logic [31:0]         Wd,
  output logic [31:0]         Rd,
  input  logic                IntAck,
  output logic                IRQ,
  output logic [IRQ_ID_W-1:0] IntId,
  output logic [HWINT_W-1:0]  HWInt
);

  irq_state_e          state_q, state_d;
  logic [N-1:0]        pend_q, pend_d;
  logic [N-1:0]        mask_q, mask_d;
  logic                en_q, en_d;
  logic                cur_valid_q, cur_valid_d;
  logic [IRQ_ID_W-1:0] cur_id_q, cur_id_d;
  logic                irq_q, irq_d;
  logic [IRQ_ID_W-1:0] intid_q, intid_d;
  logic [HWINT_W-1:0]  hwint_q;

  logic [N-1:0]        elig;
  logic [N-1:0]        clr;
  logic                elig_any;
  logic [IRQ_ID_W-1:0] elig_id;
  logic                wr_pend, wr_mask, wr_cur, wr_ctrl;
  logic                ack, eoi;
  logic                wd_unused;

  assign wr_pend   = We && (Addr == REG_PEND);
  assign wr_mask   = We && (Addr == REG_MASK);
  assign wr_cur    = We && (Addr == REG_CUR);
  assign wr_ctrl   = We && (Addr == REG_CTRL);
  assign ack       = IntAck && (state_q == ST_REQ);
  assign eoi       = wr_cur && (state_q == ST_SERVICE);
  assign wd_unused = ^Wd[31:N];

  assign elig = en_q ? (pend_q & mask_q) : '0;

  prio_enc #(.N(N)) u_prio (
    .req_i (elig),
    .any_o (elig_any),
    .id_o  (elig_id)
  );

  // The ack clears the line it captured; a same-cycle pulse still sets it.
  always_comb begin
    clr = wr_pend ? Wd[N-1:0] : '0;
    if (ack) clr = clr | (N'(1) << intid_q);
    pend_d      = (pend_q & ~clr) | DevIRQ;
    mask_d      = wr_mask ? Wd[N-1:0] : mask_q;
    en_d        = wr_ctrl ? Wd[0] : en_q;
    cur_valid_d = cur_valid_q;
    cur_id_d    = cur_id_q;
    if (ack) begin
      cur_valid_d = 1'b1;
      cur_id_d    = intid_q;
    end else if (eoi) begin
      cur_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (elig_any) state_d = ST_REQ;
      ST_REQ: begin
        if (IntAck)         state_d = ST_SERVICE;
        else if (!elig_any) state_d = ST_IDLE;
      end
      ST_SERVICE: if (wr_cur) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    irq_d   = (state_d == ST_REQ);
    intid_d = irq_d ? elig_id : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      mask_q      <= '0;
      en_q        <= 1'b0;
      cur_valid_q <= 1'b0;
      cur_id_q    <= '0;
      irq_q       <= 1'b0;
      intid_q     <= '0;
      hwint_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      en_q        <= en_d;
      cur_valid_q <= cur_valid_d;
      cur_id_q    <= cur_id_d;
      irq_q       <= irq_d;
      intid_q     <= intid_d;
      hwint_q     <= HWINT_W'(pend_q & mask_q);
    end
  end

  always_comb begin
    case (Addr)
      REG_PEND: Rd = 32'(pend_q);
      REG_MASK: Rd = 32'(mask_q);
      REG_CUR:  Rd = {cur_valid_q, 28'b0, cur_id_q};
      default:  Rd = {31'b0, en_q};
    endcase
  end

  assign IRQ   = irq_q;
  assign IntId = intid_q;
  assign HWInt = hwint_q;

endmodule
